// File: rtl/fir_dac_return_if.sv
// Stream bundle between the stereo FIR outputs, the return block and the audio core DAC inputs.
// The slave side is the return block; the master side is whatever drives FIR results and DAC ready.
interface fir_dac_return_if;
   logic [31:0] fir_left_output_data;
   logic        fir_left_output_valid;
   logic [1:0]  fir_left_output_error;
   logic [31:0] fir_right_output_data;
   logic        fir_right_output_valid;
   logic [1:0]  fir_right_output_error;
   logic [31:0] left_input_data;
   logic        left_input_valid;
   logic        left_input_ready;
   logic [31:0] right_input_data;
   logic        right_input_valid;
   logic        right_input_ready;

   modport master (
      output fir_left_output_data, fir_left_output_valid, fir_left_output_error,
      output fir_right_output_data, fir_right_output_valid, fir_right_output_error,
      output left_input_ready, right_input_ready,
      input  left_input_data, left_input_valid, right_input_data, right_input_valid
   );

   modport slave (
      input  fir_left_output_data, fir_left_output_valid, fir_left_output_error,
      input  fir_right_output_data, fir_right_output_valid, fir_right_output_error,
      input  left_input_ready, right_input_ready,
      output left_input_data, left_input_valid, right_input_data, right_input_valid
   );
endinterface

// File: rtl/fir_dac_return.sv
// FIR-to-DAC return path: round/shift/saturate per channel into a FWFT FIFO, 1-clock push-to-valid latency.
// FIR side has no backpressure: samples arriving at a full FIFO without a same-cycle pop are dropped and counted.
module fir_dac_chan #(
   parameter int DEPTH = 8,
   parameter int SHIFT = 15,
   parameter int AUD_W = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        fir_vld_i,
   input  logic [31:0] fir_dat_i,
   input  logic [1:0]  fir_err_i,
   output logic        out_vld_o,
   output logic [31:0] out_dat_o,
   input  logic        out_rdy_i,
   output logic [15:0] drop_cnt_o,
   output logic        err_o,
   output logic        sat_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic signed [32:0] RND  = (33'sd1 <<< SHIFT) >>> 1;
   localparam logic signed [32:0] MAXV = (33'sd1 <<< (AUD_W - 1)) - 33'sd1;
   localparam logic signed [32:0] MINV = -MAXV - 33'sd1;

   logic signed [32:0] rnd_sum, shifted;
   logic               over, under, bad;
   logic [31:0]        sample;

   logic [31:0]   mem_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   drop_q, drop_d;
   logic          err_q, err_d, sat_q, sat_d;
   logic          pop, push, drop, full;

   // Sign-extended to 33 bits so the rounding add can never wrap.
   always_comb begin
      rnd_sum = $signed({fir_dat_i[31], fir_dat_i}) + RND;
      shifted = rnd_sum >>> SHIFT;
      over    = shifted > MAXV;
      under   = shifted < MINV;
      bad     = fir_err_i != 2'b00;
      if (bad)        sample = '0;
      else if (over)  sample = MAXV[31:0];
      else if (under) sample = MINV[31:0];
      else            sample = shifted[31:0];
   end

   assign full = cnt_q == CW'(DEPTH);
   assign pop  = (cnt_q != '0) && out_rdy_i;
   assign push = fir_vld_i && (!full || pop);
   assign drop = fir_vld_i && full && !pop;

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (pop) begin
         rd_d  = rd_q + PW'(1);
         cnt_d = cnt_d - CW'(1);
      end
      if (push) begin
         wr_d  = wr_q + PW'(1);
         cnt_d = cnt_d + CW'(1);
      end
      drop_d = drop_q;
      err_d  = err_q;
      sat_d  = sat_q;
      if (clr_i) begin
         drop_d = '0;
         err_d  = 1'b0;
         sat_d  = 1'b0;
      end else begin
         if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
         if (fir_vld_i && bad)                   err_d = 1'b1;
         if (fir_vld_i && !bad && (over || under)) sat_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         drop_q <= '0;
         err_q  <= 1'b0;
         sat_q  <= 1'b0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         drop_q <= drop_d;
         err_q  <= err_d;
         sat_q  <= sat_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q] <= sample;
   end

   assign out_vld_o  = cnt_q != '0;
   assign out_dat_o  = out_vld_o ? mem_q[rd_q] : '0;
   assign drop_cnt_o = drop_q;
   assign err_o      = err_q;
   assign sat_o      = sat_q;
endmodule

module fir_dac_return #(
   parameter int DEPTH = 8,
   parameter int SHIFT = 15,
   parameter int AUD_W = 16
) (
   input  logic               clk_clk,
   input  logic               reset_reset,
   fir_dac_return_if.slave    bus,
   input  logic               clear_status,
   output logic [15:0]        left_drop_cnt,
   output logic [15:0]        right_drop_cnt,
   output logic [1:0]         err_sticky,
   output logic [1:0]         sat_sticky
);
   logic l_err, r_err, l_sat, r_sat;

   fir_dac_chan #(.DEPTH(DEPTH), .SHIFT(SHIFT), .AUD_W(AUD_W)) u_left (
      .clk_i      (clk_clk),
      .rst_i      (reset_reset),
      .clr_i      (clear_status),
      .fir_vld_i  (bus.fir_left_output_valid),
      .fir_dat_i  (bus.fir_left_output_data),
      .fir_err_i  (bus.fir_left_output_error),
      .out_vld_o  (bus.left_input_valid),
      .out_dat_o  (bus.left_input_data),
      .out_rdy_i  (bus.left_input_ready),
      .drop_cnt_o (left_drop_cnt),
      .err_o      (l_err),
      .sat_o      (l_sat)
   );

   fir_dac_chan #(.DEPTH(DEPTH), .SHIFT(SHIFT), .AUD_W(AUD_W)) u_right (
      .clk_i      (clk_clk),
      .rst_i      (reset_reset),
      .clr_i      (clear_status),
      .fir_vld_i  (bus.fir_right_output_valid),
      .fir_dat_i  (bus.fir_right_output_data),
      .fir_err_i  (bus.fir_right_output_error),
      .out_vld_o  (bus.right_input_valid),
      .out_dat_o  (bus.right_input_data),
      .out_rdy_i  (bus.right_input_ready),
      .drop_cnt_o (right_drop_cnt),
      .err_o      (r_err),
      .sat_o      (r_sat)
   );

   assign err_sticky = {r_err, l_err};
   assign sat_sticky = {r_sat, l_sat};
endmodule

// File: tb/tb_fir_dac_return.sv
// Directed plus random bench for fir_dac_return; reference is a queue-per-channel model with integer arithmetic.
module tb_fir_dac_return;
   localparam int DEPTH = 8;
   localparam int SHIFT = 15;
   localparam int AUD_W = 16;

   logic        clk_clk = 1'b0;
   logic        reset_reset;
   logic        clear_status;
   logic [15:0] left_drop_cnt, right_drop_cnt;
   logic [1:0]  err_sticky, sat_sticky;

   always #5 clk_clk = ~clk_clk;

   fir_dac_return_if bus ();

   fir_dac_return #(.DEPTH(DEPTH), .SHIFT(SHIFT), .AUD_W(AUD_W)) dut (
      .clk_clk        (clk_clk),
      .reset_reset    (reset_reset),
      .bus            (bus),
      .clear_status   (clear_status),
      .left_drop_cnt  (left_drop_cnt),
      .right_drop_cnt (right_drop_cnt),
      .err_sticky     (err_sticky),
      .sat_sticky     (sat_sticky)
   );

   int          n_asrt = 0;
   int          n_fail = 0;
   logic [31:0] mq [2][$];
   int          exp_drop [2];
   bit          exp_err [2];
   bit          exp_sat [2];

   function automatic logic [31:0] conv(input logic [31:0] d, output bit sat);
      longint v, lim;
      v = longint'($signed(d));
      v = v + ((longint'(1) << SHIFT) >> 1);
      v = v >>> SHIFT;
      lim = longint'(1) << (AUD_W - 1);
      sat = 1'b0;
      if (v > lim - 1) begin v = lim - 1; sat = 1'b1; end
      else if (v < -lim) begin v = -lim; sat = 1'b1; end
      return v[31:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asrt++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("l_vld",  {31'd0, bus.left_input_valid},  {31'd0, mq[0].size() != 0});
      chk("r_vld",  {31'd0, bus.right_input_valid}, {31'd0, mq[1].size() != 0});
      chk("l_dat",  bus.left_input_data,  mq[0].size() != 0 ? mq[0][0] : 32'd0);
      chk("r_dat",  bus.right_input_data, mq[1].size() != 0 ? mq[1][0] : 32'd0);
      chk("l_drop", {16'd0, left_drop_cnt},  32'(exp_drop[0]));
      chk("r_drop", {16'd0, right_drop_cnt}, 32'(exp_drop[1]));
      chk("err",    {30'd0, err_sticky}, {30'd0, exp_err[1], exp_err[0]});
      chk("sat",    {30'd0, sat_sticky}, {30'd0, exp_sat[1], exp_sat[0]});
   endtask

   task automatic model_chan(input int ch, input bit vld, input logic [31:0] dat,
                             input logic [1:0] err, input bit rdy, input bit clr);
      logic [31:0] s;
      bit          sat, pop;
      s   = conv(dat, sat);
      pop = mq[ch].size() != 0 && rdy;
      if (pop) void'(mq[ch].pop_front());
      if (vld) begin
         if (err != 2'b00) s = 32'd0;
         if (mq[ch].size() < DEPTH) mq[ch].push_back(s);
         else if (!clr && exp_drop[ch] < 65535) exp_drop[ch]++;
      end
      if (clr) begin
         exp_drop[ch] = 0;
         exp_err[ch]  = 1'b0;
         exp_sat[ch]  = 1'b0;
      end else if (vld) begin
         if (err != 2'b00) exp_err[ch] = 1'b1;
         else if (sat)     exp_sat[ch] = 1'b1;
      end
   endtask

   task automatic cyc(input bit lv, input logic [31:0] ld, input logic [1:0] le,
                      input bit rv, input logic [31:0] rd, input logic [1:0] re,
                      input bit lr, input bit rr, input bit clr);
      bus.fir_left_output_valid  = lv;
      bus.fir_left_output_data   = ld;
      bus.fir_left_output_error  = le;
      bus.fir_right_output_valid = rv;
      bus.fir_right_output_data  = rd;
      bus.fir_right_output_error = re;
      bus.left_input_ready       = lr;
      bus.right_input_ready      = rr;
      clear_status               = clr;
      model_chan(0, lv, ld, le, lr, clr);
      model_chan(1, rv, rd, re, rr, clr);
      @(posedge clk_clk);
      #1;
      check_all();
   endtask

   task automatic lpush(input logic [31:0] d, input bit lr);
      cyc(1'b1, d, 2'b00, 1'b0, 32'd0, 2'b00, lr, 1'b0, 1'b0);
   endtask

   task automatic lidle(input bit lr);
      cyc(1'b0, 32'd0, 2'b00, 1'b0, 32'd0, 2'b00, lr, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      reset_reset                = 1'b1;
      bus.fir_left_output_valid  = 1'b0;
      bus.fir_right_output_valid = 1'b0;
      bus.left_input_ready       = 1'b0;
      bus.right_input_ready      = 1'b0;
      clear_status               = 1'b0;
      @(posedge clk_clk);
      #1;
      reset_reset = 1'b0;
      for (int c = 0; c < 2; c++) begin
         mq[c].delete();
         exp_drop[c] = 0;
         exp_err[c]  = 1'b0;
         exp_sat[c]  = 1'b0;
      end
      check_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] head;
      bus.fir_left_output_data   = '0;
      bus.fir_left_output_error  = '0;
      bus.fir_right_output_data  = '0;
      bus.fir_right_output_error = '0;
      reset_reset = 1'b1;
      @(posedge clk_clk);
      do_reset();
      chk("rst_l_vld", {31'd0, bus.left_input_valid}, 32'd0);
      chk("rst_l_drop", {16'd0, left_drop_cnt}, 32'd0);

      // conversions and push-while-empty latency
      lpush(32'h0000_4000, 1'b1);
      chk("conv_4000", bus.left_input_data, 32'h0000_0001);
      lpush(32'h0000_8000, 1'b1);
      chk("conv_8000", bus.left_input_data, 32'h0000_0001);
      lpush(32'hFFFF_C000, 1'b1);
      chk("conv_ffffc000", bus.left_input_data, 32'h0000_0000);
      lidle(1'b1);
      chk("conv_empty", {31'd0, bus.left_input_valid}, 32'd0);

      // saturation
      lpush(32'h3FFF_FFFF, 1'b1);
      chk("sat_pos", bus.left_input_data, 32'h0000_7FFF);
      lpush(32'h8000_0000, 1'b1);
      chk("sat_neg", bus.left_input_data, 32'hFFFF_8000);
      chk("sat_sticky", {30'd0, sat_sticky}, 32'd1);
      cyc(1'b0, 32'd0, 2'b00, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0, 1'b1);
      chk("sat_clr", {30'd0, sat_sticky}, 32'd0);

      // overflow: 10 pushes with ready low
      for (int i = 0; i < 10; i++) lpush(32'(i) << 15, 1'b0);
      chk("ovf_drop", {16'd0, left_drop_cnt}, 32'd2);
      for (int i = 0; i < 8; i++) begin
         chk("ovf_order", bus.left_input_data, 32'(i));
         lidle(1'b1);
      end
      chk("ovf_empty", {31'd0, bus.left_input_valid}, 32'd0);

      // full FIFO with simultaneous push and pop
      for (int i = 0; i < 8; i++) lpush(32'(i + 10) << 15, 1'b0);
      lpush(32'h0003_0000, 1'b1);
      chk("fpp_drop", {16'd0, left_drop_cnt}, 32'd2);
      chk("fpp_vld", {31'd0, bus.left_input_valid}, 32'd1);
      for (int i = 0; i < 7; i++) lidle(1'b1);
      chk("fpp_new", bus.left_input_data, 32'd6);
      lidle(1'b1);

      // error-flagged right sample
      cyc(1'b0, 32'd0, 2'b00, 1'b1, 32'h1234_5678, 2'b01, 1'b0, 1'b0, 1'b0);
      chk("err_dat", bus.right_input_data, 32'd0);
      chk("err_vld", {31'd0, bus.right_input_valid}, 32'd1);
      chk("err_sticky", {30'd0, err_sticky}, 32'd2);
      chk("err_left", {31'd0, bus.left_input_valid}, 32'd0);

      // reset mid-stream
      for (int i = 0; i < 5; i++) lpush(32'(i + 1) << 15, 1'b0);
      do_reset();
      chk("rst_mid_vld", {31'd0, bus.left_input_valid}, 32'd0);
      chk("rst_mid_err", {30'd0, err_sticky}, 32'd0);

      // clear_status keeps buffered data
      for (int i = 0; i < 10; i++) lpush(32'(i + 3) << 15, 1'b0);
      cyc(1'b1, 32'h0000_8000, 2'b10, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      head = bus.left_input_data;
      cyc(1'b1, 32'h0000_8000, 2'b00, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b1);
      chk("clr_drop", {16'd0, left_drop_cnt}, 32'd0);
      chk("clr_err", {30'd0, err_sticky}, 32'd0);
      chk("clr_keep", bus.left_input_data, 32'd3);
      chk("clr_head", {31'd0, bus.left_input_valid}, 32'd1);
      if (head !== 32'd3) chk("clr_head_before", head, 32'd3);

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic [31:0] ld, rd;
         ld = $urandom;
         rd = $urandom;
         if ($urandom_range(0, 1) == 1) ld = {{8{ld[23]}}, ld[23:0]};
         if ($urandom_range(0, 1) == 1) rd = {{8{rd[23]}}, rd[23:0]};
         cyc($urandom_range(0, 2) != 0, ld, ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
             $urandom_range(0, 2) != 0, rd, ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
